// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, internal baud divider,
// configurable data width, optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_in,
   input  logic                          nrst_in,
   input  logic                          data_valid_in,
   input  logic [DATA_BITS-1:0]          tx_data_in,
   output logic                          data_ready_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
   output logic                          tx_serial_out,
   output logic                          tx_busy_out,
   output logic                          tx_done_out
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int IDX_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST  = (STOP_BITS == 2);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic [2:0]           state;
   logic [CNT_W-1:0]     clk_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 parity_bit;
   logic                 tx_reg;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic                 frame_end;

   assign bit_end        = (clk_cnt == CNT_LAST);
   assign frame_end      = (state == S_STOP) && (stop_cnt == STOP_LAST) && bit_end;
   assign data_ready_out = (count != FULL_COUNT);
   assign push           = data_valid_in && data_ready_out;
   // Popping at the end of the last stop bit is what gives zero-gap back-to-back frames
   assign pop            = (count != '0) && ((state == S_IDLE) || frame_end);

   assign fifo_count_out = count;
   assign tx_serial_out  = tx_reg;
   assign tx_busy_out    = (state != S_IDLE);
   assign tx_done_out    = frame_end;

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr] <= tx_data_in;
      end
   end

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Parity is latched together with the popped word so it never sees later bus activity
   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state      <= S_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         stop_cnt   <= 1'b0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx_reg     <= 1'b1;
      end else begin
         clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
         if (pop) begin
            shift_reg  <= fifo_mem[rd_ptr];
            parity_bit <= (^fifo_mem[rd_ptr]) ^ (PARITY == 2);
            tx_reg     <= 1'b0;
            clk_cnt    <= '0;
            state      <= S_START;
         end else begin
            case (state)
               S_IDLE: begin
                  tx_reg  <= 1'b1;
                  clk_cnt <= '0;
               end
               S_START: begin
                  if (bit_end) begin
                     tx_reg    <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_idx   <= '0;
                     state     <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (bit_end) begin
                     if (bit_idx == IDX_LAST) begin
                        if (PARITY != 0) begin
                           tx_reg <= parity_bit;
                           state  <= S_PARITY;
                        end else begin
                           tx_reg   <= 1'b1;
                           stop_cnt <= 1'b0;
                           state    <= S_STOP;
                        end
                     end else begin
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 1'b1;
                     end
                  end
               end
               S_PARITY: begin
                  if (bit_end) begin
                     tx_reg   <= 1'b1;
                     stop_cnt <= 1'b0;
                     state    <= S_STOP;
                  end
               end
               S_STOP: begin
                  if (bit_end) begin
                     if (stop_cnt == STOP_LAST) begin
                        state <= S_IDLE;
                     end else begin
                        stop_cnt <= 1'b1;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 7E1, 7O1, 8N2) checked every cycle
// against a frame-timer reference model, plus directed timing checks.
module tb_uart_tx_fifo;

   logic       clk_in = 1'b0;
   logic       nrst_in = 1'b1;
   logic [3:0] tvalid = '0;
   logic [8:0] tdata [4];
   logic [3:0] tx;
   logic [3:0] busy;
   logic [3:0] done;
   logic [3:0] ready;
   logic [2:0] cnt [4];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int         mhead [4];
   int         mtail [4];
   int         mtimer [4];
   logic [8:0] mword [4];
   logic [8:0] mbuf [4][8];

   int dcnt [4];
   int dlast [4];
   int dgap [4];

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk_in(clk_in), .nrst_in(nrst_in), .data_valid_in(tvalid[0]), .tx_data_in(tdata[0][7:0]),
      .data_ready_out(ready[0]), .fifo_count_out(cnt[0]), .tx_serial_out(tx[0]), .tx_busy_out(busy[0]), .tx_done_out(done[0]));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7e1 (
      .clk_in(clk_in), .nrst_in(nrst_in), .data_valid_in(tvalid[1]), .tx_data_in(tdata[1][6:0]),
      .data_ready_out(ready[1]), .fifo_count_out(cnt[1]), .tx_serial_out(tx[1]), .tx_busy_out(busy[1]), .tx_done_out(done[1]));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7o1 (
      .clk_in(clk_in), .nrst_in(nrst_in), .data_valid_in(tvalid[2]), .tx_data_in(tdata[2][6:0]),
      .data_ready_out(ready[2]), .fifo_count_out(cnt[2]), .tx_serial_out(tx[2]), .tx_busy_out(busy[2]), .tx_done_out(done[2]));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
      .clk_in(clk_in), .nrst_in(nrst_in), .data_valid_in(tvalid[3]), .tx_data_in(tdata[3][7:0]),
      .data_ready_out(ready[3]), .fifo_count_out(cnt[3]), .tx_serial_out(tx[3]), .tx_busy_out(busy[3]), .tx_done_out(done[3]));

   function automatic int dbits(input int k);
      return (k == 1 || k == 2) ? 7 : 8;
   endfunction

   function automatic int pmode(input int k);
      return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
   endfunction

   function automatic int sbits(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   function automatic int flen(input int k);
      return 10 * (1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k));
   endfunction

   // Line level for bit slot 'pos' of a frame: start, data LSB first, parity, stops
   function automatic logic frameBit(input int k, input logic [8:0] w, input int pos);
      int ones;
      ones = 0;
      if (pos == 0) return 1'b0;
      if (pos <= dbits(k)) return w[pos-1];
      if (pmode(k) != 0 && pos == dbits(k) + 1) begin
         for (int i = 0; i < dbits(k); i++) ones += int'(w[i]);
         return ((ones % 2) == 1) != (pmode(k) == 2);
      end
      return 1'b1;
   endfunction

   // Reference model: each frame is a countdown of flen clocks; a queued word starts
   // a new frame whenever the line is idle or the current frame is in its last clock
   initial forever begin
      @(posedge clk_in or negedge nrst_in);
      for (int k = 0; k < 4; k++) begin
         if (!nrst_in) begin
            mhead[k]  = 0;
            mtail[k]  = 0;
            mtimer[k] = 0;
         end else begin
            bit acc;
            acc = tvalid[k] && ((mtail[k] - mhead[k]) != 4);
            if ((mtail[k] - mhead[k]) > 0 && mtimer[k] <= 1) begin
               mword[k]  = mbuf[k][mhead[k] % 8];
               mhead[k]  = mhead[k] + 1;
               mtimer[k] = flen(k);
            end else if (mtimer[k] > 0) begin
               mtimer[k] = mtimer[k] - 1;
            end
            if (acc) begin
               mbuf[k][mtail[k] % 8] = tdata[k] & 9'((1 << dbits(k)) - 1);
               mtail[k] = mtail[k] + 1;
            end
         end
      end
   end

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input int k);
      int   t;
      logic etx;
      t   = mtimer[k];
      etx = (t == 0) ? 1'b1 : frameBit(k, mword[k], (flen(k) - t) / 10);
      cmp($sformatf("tx[%0d]", k), 32'(tx[k]), 32'(etx));
      cmp($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(t > 0));
      cmp($sformatf("done[%0d]", k), 32'(done[k]), 32'(t == 1));
      cmp($sformatf("ready[%0d]", k), 32'(ready[k]), 32'((mtail[k] - mhead[k]) != 4));
      cmp($sformatf("count[%0d]", k), 32'(cnt[k]), 32'(mtail[k] - mhead[k]));
   endtask

   initial forever begin
      @(negedge clk_in);
      for (int k = 0; k < 4; k++) begin
         checkOutput(k);
         if (done[k] === 1'b1) begin
            dgap[k]  = cyc - dlast[k];
            dlast[k] = cyc;
            dcnt[k]  = dcnt[k] + 1;
         end
      end
   end

   // Holds valid with the word until the model's FIFO can take it
   task automatic applyStimulus(input int k, input logic [8:0] w);
      bit acc;
      int n;
      tvalid[k] = 1'b1;
      tdata[k]  = w;
      n = 0;
      do begin
         acc = ((mtail[k] - mhead[k]) != 4);
         @(negedge clk_in);
         n++;
      end while (!acc && n < 5000);
      cmp("push_accepted", 32'(acc), 32'd1);
   endtask

   task automatic waitIdle(input int k);
      int n;
      n = 0;
      while ((mtimer[k] != 0 || mtail[k] != mhead[k]) && n < 20000) begin
         @(negedge clk_in);
         n++;
      end
      cmp("idle_reached", 32'(n < 20000), 32'd1);
   endtask

   initial begin
      int d0;
      int cstart;
      int n;
      for (int k = 0; k < 4; k++) begin
         tdata[k] = '0; dcnt[k] = 0; dlast[k] = 0; dgap[k] = 0;
         mhead[k] = 0; mtail[k] = 0; mtimer[k] = 0; mword[k] = '0;
      end
      #1 nrst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      cmp("rst_tx", 32'(tx[0]), 32'd1);
      cmp("rst_ready", 32'(ready[0]), 32'd1);
      cmp("rst_count", 32'(cnt[0]), 32'd0);
      nrst_in = 1'b1;
      @(negedge clk_in);

      // 8N1 0xA5: start edge one clock after the accepting edge, done at frame clock 100
      d0 = dcnt[0];
      applyStimulus(0, 9'h0A5);
      tvalid[0] = 1'b0;
      cmp("t1_idle_before_start", 32'(tx[0]), 32'd1);
      @(negedge clk_in);
      cstart = cyc;
      cmp("t1_start_low", 32'(tx[0]), 32'd0);
      cmp("t1_busy", 32'(busy[0]), 32'd1);
      waitIdle(0);
      cmp("t1_done_offset", 32'(dlast[0] - cstart), 32'd99);
      cmp("t1_done_count", 32'(dcnt[0] - d0), 32'd1);

      // 7-bit 0x23 has three ones: even parity bit 1, odd parity bit 0 (slot 8, clocks 80..89)
      applyStimulus(1, 9'h023);
      tvalid[1] = 1'b0;
      repeat (86) @(negedge clk_in);
      cmp("t2_even_parity", 32'(tx[1]), 32'd1);
      waitIdle(1);
      applyStimulus(2, 9'h023);
      tvalid[2] = 1'b0;
      repeat (86) @(negedge clk_in);
      cmp("t2_odd_parity", 32'(tx[2]), 32'd0);
      waitIdle(2);

      // Six words with valid held: the sixth stalls until the first frame ends
      d0 = dcnt[0];
      for (int i = 0; i < 6; i++) applyStimulus(0, 9'(8'h11 + i));
      tvalid[0] = 1'b0;
      cmp("t3_count_full", 32'(cnt[0]), 32'd4);
      cmp("t3_ready_low", 32'(ready[0]), 32'd0);
      waitIdle(0);
      cmp("t3_done_count", 32'(dcnt[0] - d0), 32'd6);

      // Valid raised the cycle before a pop while full: refused at the pop edge, taken next
      for (int i = 0; i < 5; i++) applyStimulus(0, 9'(8'h31 + i));
      tvalid[0] = 1'b0;
      n = 0;
      while (mtimer[0] != 1 && n < 2000) begin
         @(negedge clk_in);
         n++;
      end
      cmp("t4_pop_edge_found", 32'(n < 2000), 32'd1);
      cstart = cyc;
      applyStimulus(0, 9'h077);
      tvalid[0] = 1'b0;
      cmp("t4_accept_delay", 32'(cyc - cstart), 32'd2);
      cmp("t4_count", 32'(cnt[0]), 32'd4);
      waitIdle(0);

      // Reset in data bit 3 of 0x3C with two words queued
      applyStimulus(0, 9'h03C);
      applyStimulus(0, 9'h001);
      applyStimulus(0, 9'h002);
      tvalid[0] = 1'b0;
      repeat (44) @(negedge clk_in);
      d0 = dcnt[0];
      #2 nrst_in = 1'b0;
      #1;
      cmp("t5_tx_high", 32'(tx[0]), 32'd1);
      cmp("t5_count_zero", 32'(cnt[0]), 32'd0);
      cmp("t5_busy_low", 32'(busy[0]), 32'd0);
      cmp("t5_done_low", 32'(done[0]), 32'd0);
      repeat (3) @(negedge clk_in);
      nrst_in = 1'b1;
      applyStimulus(0, 9'h05A);
      tvalid[0] = 1'b0;
      waitIdle(0);
      cmp("t5_done_after_reset", 32'(dcnt[0] - d0), 32'd1);

      // Two stop bits: done pulses 110 clocks apart
      d0 = dcnt[3];
      applyStimulus(3, 9'h0C3);
      applyStimulus(3, 9'h03C);
      tvalid[3] = 1'b0;
      waitIdle(3);
      cmp("t6_done_count", 32'(dcnt[3] - d0), 32'd2);
      cmp("t6_done_gap", 32'(dgap[3]), 32'd110);

      // Random traffic on all instances, with one reset in the middle
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 4; k++) begin
            tvalid[k] = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            tdata[k]  = 9'($urandom);
         end
         if (i == 1500) #2 nrst_in = 1'b0;
         if (i == 1503) nrst_in = 1'b1;
         @(negedge clk_in);
      end
      tvalid = '0;
      for (int k = 0; k < 4; k++) waitIdle(k);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
